// File: rtl/m_cp0_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// m_cp0_ctrl_pkg
//   Shared CP0 definitions for the M-stage exception/interrupt controller:
//   register numbers, exception codes, field bit positions, the packed views
//   of SR and Cause, and the helpers that map those views to and from the
//   32-bit architectural register images.
// -----------------------------------------------------------------------------
package m_cp0_ctrl_pkg;

  localparam int HWINT_W = 6;
  localparam int EXC_W   = 5;

  localparam logic [31:0] EPC_RST_DEFAULT = 32'h0000_3000;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  // Exception codes
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  // Field bit positions
  localparam int IM_MSB  = 15;
  localparam int IM_LSB  = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_MSB  = 15;
  localparam int IP_LSB  = 10;
  localparam int EXC_MSB = 6;
  localparam int EXC_LSB = 2;

  typedef struct packed {
    logic [HWINT_W-1:0] im;
    logic               exl;
    logic               ie;
  } sr_t;

  typedef struct packed {
    logic               bd;
    logic [HWINT_W-1:0] ip;
    logic [EXC_W-1:0]   exc_code;
  } cause_t;

  // Architectural image of SR; unimplemented bits read 0.
  function automatic logic [31:0] pack_sr(input sr_t s);
    logic [31:0] r;
    r                 = '0;
    r[IM_MSB:IM_LSB]  = s.im;
    r[EXL_BIT]        = s.exl;
    r[IE_BIT]         = s.ie;
    return r;
  endfunction

  // mtc0 SR keeps only the implemented fields.
  function automatic sr_t unpack_sr(input logic [31:0] w);
    sr_t s;
    s.im  = w[IM_MSB:IM_LSB];
    s.exl = w[EXL_BIT];
    s.ie  = w[IE_BIT];
    return s;
  endfunction

  // Architectural image of Cause; unimplemented bits read 0.
  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] r;
    r                  = '0;
    r[BD_BIT]          = c.bd;
    r[IP_MSB:IP_LSB]   = c.ip;
    r[EXC_MSB:EXC_LSB] = c.exc_code;
    return r;
  endfunction

endpackage

// File: rtl/m_cp0_ctrl_if.sv
// -----------------------------------------------------------------------------
// m_cp0_ctrl_if
//   M-stage <-> CP0 bus. The pipeline (master) drives the M-stage instruction
//   attributes, the external interrupt levels and the mtc0/mfc0/eret controls;
//   CP0 (slave) returns read data, the take-exception strobe and the EPC.
//
//   Timing contract: there is no valid/ready handshake. Every input is
//   sampled at each rising clk edge as a description of the instruction
//   currently in M (a bubble presents ExcCode=0, we=0, eret=0). IntReq,
//   M_rdata and EPC_out are combinational from the current inputs and CP0
//   state; when IntReq=1 the consumer must load the trap address and flush
//   at the same edge that CP0 records EPC/Cause/EXL.
// -----------------------------------------------------------------------------
interface m_cp0_ctrl_if;
  import m_cp0_ctrl_pkg::*;

  logic [HWINT_W-1:0] HWInt;
  logic [EXC_W-1:0]   M_ExcCode;
  logic               M_BD;
  logic [31:0]        M_PC;
  logic               M_we;
  logic [4:0]         M_addr;
  logic [31:0]        M_wdata;
  logic               M_eret;
  logic [31:0]        M_rdata;
  logic               IntReq;
  logic [31:0]        EPC_out;

  modport master (
    output HWInt, M_ExcCode, M_BD, M_PC, M_we, M_addr, M_wdata, M_eret,
    input  M_rdata, IntReq, EPC_out
  );

  modport slave (
    input  HWInt, M_ExcCode, M_BD, M_PC, M_we, M_addr, M_wdata, M_eret,
    output M_rdata, IntReq, EPC_out
  );

endinterface

// File: rtl/m_cp0_ctrl.sv
// -----------------------------------------------------------------------------
// m_cp0_ctrl
//   Coprocessor-0 exception/interrupt controller in the M stage. Holds SR,
//   Cause and EPC, arbitrates the M-stage exception against enabled external
//   interrupts, and raises IntReq (combinational, one cycle) so fetch can
//   redirect to the trap address at the same edge EPC/Cause/EXL are latched.
//
// Ports
//   clk    : single clock
//   reset  : asynchronous active-low reset; 0 clears SR/Cause/EPC at once
//   cp0    : m_cp0_ctrl_if.slave
//            in : HWInt, M_ExcCode, M_BD, M_PC, M_we, M_addr, M_wdata, M_eret
//            out: M_rdata (mfc0 data), IntReq (take strobe), EPC_out (bypassed)
// -----------------------------------------------------------------------------
module m_cp0_ctrl
  import m_cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] EPC_RST = EPC_RST_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  m_cp0_ctrl_if.slave  cp0
);

  sr_t         sr_q,    sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q,   epc_d;

  logic int_req;
  logic exc_req;
  logic take;
  logic mtc0_sr;
  logic mtc0_epc;

  // ---------------------------------------------------------------------------
  // Request arbitration, mtc0 decode, read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    int_req  = (|(cp0.HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    exc_req  = (cp0.M_ExcCode != '0) & ~sr_q.exl;
    // Gated by reset so the strobe drops the moment reset asserts, even if
    // the M-stage inputs still present an exception.
    take     = (int_req | exc_req) & reset;
    // The trapping instruction is cancelled, so its mtc0 must not commit.
    mtc0_sr  = cp0.M_we & (cp0.M_addr == CP0_SR)  & ~take;
    mtc0_epc = cp0.M_we & (cp0.M_addr == CP0_EPC) & ~take;

    cp0.IntReq  = take;
    // Bypass lets an eret right behind an mtc0 EPC see the new value.
    cp0.EPC_out = mtc0_epc ? cp0.M_wdata : epc_q;

    cp0.M_rdata = '0;
    case (cp0.M_addr)
      CP0_SR:    cp0.M_rdata = pack_sr(sr_q);
      CP0_CAUSE: cp0.M_rdata = pack_cause(cause_q);
      CP0_EPC:   cp0.M_rdata = epc_q;
      default:   cp0.M_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state: SR
  // ---------------------------------------------------------------------------
  always_comb begin
    sr_d = sr_q;
    if (take) begin
      sr_d.exl = 1'b1;
    end else begin
      if (mtc0_sr) begin
        sr_d = unpack_sr(cp0.M_wdata);
      end
      // eret is the last word on EXL when no exception is taken.
      if (cp0.M_eret) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: Cause (IP tracks HWInt every cycle; Cause is read-only to mtc0)
  // ---------------------------------------------------------------------------
  always_comb begin
    cause_d    = cause_q;
    cause_d.ip = cp0.HWInt;
    if (take) begin
      cause_d.bd       = cp0.M_BD;
      cause_d.exc_code = int_req ? EXC_INT : cp0.M_ExcCode;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: EPC (delay-slot victims restart at the branch, modulo 2^32)
  // ---------------------------------------------------------------------------
  always_comb begin
    epc_d = epc_q;
    if (take) begin
      epc_d = cp0.M_BD ? (cp0.M_PC - 32'd4) : cp0.M_PC;
    end else if (mtc0_epc) begin
      epc_d = cp0.M_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cause_q <= '0;
    else        cause_q <= cause_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) epc_q <= EPC_RST;
    else        epc_q <= epc_d;
  end

endmodule

// File: tb/tb_m_cp0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_m_cp0_ctrl
//   Table-driven bench for m_cp0_ctrl. Each row describes one M-stage cycle
//   and the combinational outputs expected in that cycle given the state left
//   by the rows before it; hand sequences cover reset behaviour.
// -----------------------------------------------------------------------------
module tb_m_cp0_ctrl;

  logic clk;
  logic reset;

  m_cp0_ctrl_if bus ();

  m_cp0_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .cp0   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  hwint;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        exp_int;
    logic [31:0] exp_rdata;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] hwint, input logic [4:0] exc, input logic bd,
                     input logic [31:0] pc, input logic we, input logic [4:0] addr,
                     input logic [31:0] wdata, input logic eret, input logic exp_int,
                     input logic [31:0] exp_rdata, input logic [31:0] exp_epc);
    vec_t v;
    v.hwint = hwint; v.exc = exc; v.bd = bd; v.pc = pc; v.we = we; v.addr = addr;
    v.wdata = wdata; v.eret = eret; v.exp_int = exp_int;
    v.exp_rdata = exp_rdata; v.exp_epc = exp_epc;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.HWInt     = v.hwint;
    bus.M_ExcCode = v.exc;
    bus.M_BD      = v.bd;
    bus.M_PC      = v.pc;
    bus.M_we      = v.we;
    bus.M_addr    = v.addr;
    bus.M_wdata   = v.wdata;
    bus.M_eret    = v.eret;
  endtask

  task automatic idle();
    bus.HWInt = '0; bus.M_ExcCode = '0; bus.M_BD = 1'b0; bus.M_PC = '0;
    bus.M_we = 1'b0; bus.M_addr = '0; bus.M_wdata = '0; bus.M_eret = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b0;

    // rows: hwint exc bd pc we addr wdata eret | intreq rdata epc_out
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b0, 32'h0,        32'h3000);     // 0 reset SR
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b1, 5'd12, 32'h401,      1'b0, 1'b0, 32'h0,        32'h3000);     // 1 mtc0 SR
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b0, 32'h401,      32'h3000);     // 2
    add(6'h01, 5'd0,  1'b0, 32'h3010, 1'b0, 5'd13, 32'h0,        1'b0, 1'b1, 32'h0,        32'h3000);     // 3 interrupt
    add(6'h01, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b0, 32'h403,      32'h3010);     // 4 EXL blocks
    add(6'h01, 5'd0,  1'b0, 32'h0,    1'b0, 5'd13, 32'h0,        1'b0, 1'b0, 32'h400,      32'h3010);     // 5 IP visible
    add(6'h01, 5'd0,  1'b0, 32'h0,    1'b0, 5'd14, 32'h0,        1'b0, 1'b0, 32'h3010,     32'h3010);     // 6
    add(6'h01, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b1, 1'b0, 32'h403,      32'h3010);     // 7 eret, pending
    add(6'h01, 5'd0,  1'b0, 32'h3040, 1'b0, 5'd12, 32'h0,        1'b0, 1'b1, 32'h401,      32'h3010);     // 8 fires after
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd14, 32'h0,        1'b1, 1'b0, 32'h3040,     32'h3040);     // 9 eret
    add(6'h00, 5'd12, 1'b1, 32'h3024, 1'b0, 5'd12, 32'h0,        1'b0, 1'b1, 32'h401,      32'h3040);     // 10 Ov in BD
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd13, 32'h0,        1'b0, 1'b0, 32'h8000_0030, 32'h3020);    // 11
    add(6'h00, 5'd4,  1'b0, 32'h3070, 1'b0, 5'd14, 32'h0,        1'b0, 1'b0, 32'h3020,     32'h3020);     // 12 masked by EXL
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b1, 1'b0, 32'h403,      32'h3020);     // 13 eret
    add(6'h01, 5'd4,  1'b0, 32'h3050, 1'b1, 5'd14, 32'h3100,     1'b0, 1'b1, 32'h3020,     32'h3020);     // 14 int beats exc, mtc0 cancelled
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd13, 32'h0,        1'b0, 1'b0, 32'h400,      32'h3050);     // 15 ExcCode=Int
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b1, 5'd14, 32'h3100,     1'b0, 1'b0, 32'h3050,     32'h3100);     // 16 EPC bypass
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd14, 32'h0,        1'b0, 1'b0, 32'h3100,     32'h3100);     // 17
    add(6'h20, 5'd0,  1'b0, 32'h0,    1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,       32'h3100);     // 18 Cause read-only
    add(6'h20, 5'd0,  1'b0, 32'h0,    1'b0, 5'd13, 32'h0,        1'b0, 1'b0, 32'h8000,     32'h3100);     // 19
    add(6'h20, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b1, 1'b0, 32'h403,      32'h3100);     // 20 eret
    add(6'h20, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b0, 32'h401,      32'h3100);     // 21 IM masks line 5
    add(6'h00, 5'd10, 1'b1, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b1, 32'h401,      32'h3100);     // 22 RI in BD at PC 0
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd14, 32'h0,        1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC); // 23 wrap
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd13, 32'h0,        1'b0, 1'b0, 32'h8000_0028, 32'hFFFF_FFFC); // 24
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b1, 1'b0, 32'h403,      32'hFFFF_FFFC); // 25 eret
    add(6'h00, 5'd5,  1'b0, 32'h3060, 1'b0, 5'd12, 32'h0,        1'b1, 1'b1, 32'h401,      32'hFFFF_FFFC); // 26 eret+exc
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b0, 32'h403,      32'h3060);     // 27 EXL stays 1
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd13, 32'h0,        1'b0, 1'b0, 32'h14,       32'h3060);     // 28
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b1, 5'd12, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h403,     32'h3060);     // 29 masked write
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b0, 32'hFC03,     32'h3060);     // 30
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b1, 5'd12, 32'h0,        1'b0, 1'b0, 32'hFC03,     32'h3060);     // 31
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd12, 32'h0,        1'b0, 1'b0, 32'h0,        32'h3060);     // 32
    add(6'h00, 5'd0,  1'b0, 32'h0,    1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,        32'h3060);     // 33 unimpl reg

    // IntReq must stay low while reset is held, even with an exception presented
    @(negedge clk);
    bus.M_ExcCode = 5'd12;
    #1;
    check("intreq_in_reset", {31'b0, bus.IntReq}, 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check($sformatf("v%0d_intreq", i), {31'b0, bus.IntReq}, {31'b0, vq[i].exp_int});
      check($sformatf("v%0d_rdata", i),  bus.M_rdata, vq[i].exp_rdata);
      check($sformatf("v%0d_epc_out", i), bus.EPC_out, vq[i].exp_epc);
    end

    // Mid-cycle reset during a pending exception: state clears without a clock
    @(negedge clk);
    idle();
    bus.M_ExcCode = 5'd12;
    bus.M_PC      = 32'h3090;
    #1;
    check("pre_reset_intreq", {31'b0, bus.IntReq}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("async_intreq", {31'b0, bus.IntReq}, 32'h0);
    check("async_epc_out", bus.EPC_out, 32'h3000);
    bus.M_addr = 5'd12;
    #1;
    check("async_sr", bus.M_rdata, 32'h0);
    bus.M_addr = 5'd13;
    #1;
    check("async_cause", bus.M_rdata, 32'h0);
    bus.M_addr = 5'd14;
    #1;
    check("async_epc", bus.M_rdata, 32'h3000);
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.M_addr = 5'd14;
    #1;
    check("post_reset_epc", bus.M_rdata, 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
